// File: rtl/ram_port_arbiter.sv
// Round-robin sequencer that shares the single RAM port between NREQ cache-side requesters.
// Locked owners keep the port across back-to-back accesses; stalled accesses abort after TIMEOUT cycles.
module ram_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_store,
    output logic [NREQ-1:0]          req_wait,
    output logic [DATA_W-1:0]        req_load,
    output logic [NREQ-1:0]          req_err,
    output logic [NREQ-1:0]          grant,
    output logic                     ram_ren,
    output logic                     ram_wen,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_store,
    input  logic [DATA_W-1:0]        ram_load,
    input  logic [1:0]               ram_state
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, XFER} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;

    state_t            state;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     rr_ptr;
    logic [TW-1:0]     tcount;

    logic [NREQ-1:0]   active;
    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] store_arr [NREQ];
    logic              pick_valid;
    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     next_ptr;
    logic              owner_active;
    logic              is_access;
    logic              is_error;
    logic              timed_out;
    logic              complete;
    logic              abort_x;

    assign active = req_ren | req_wen;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            store_arr[i] = req_store[i*DATA_W +: DATA_W];
        end
    end

    // First active requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic [OW-1:0] cand;
        int unsigned   idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx  = (32'(rr_ptr) + k) % NREQ;
            cand = OW'(idx);
            if (!pick_valid && active[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign next_ptr     = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign owner_active = active[owner];
    assign is_access    = (ram_state == RAM_ACCESS);
    assign is_error     = (ram_state == RAM_ERROR);
    assign timed_out    = (tcount == TW'(TIMEOUT - 1));
    assign complete     = (state == XFER) && owner_active && is_access;
    assign abort_x      = (state == XFER) && owner_active && !is_access && (is_error || timed_out);

    always_comb begin
        grant     = '0;
        req_wait  = '1;
        req_err   = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        req_load  = '0;
        if (state == XFER) begin
            grant[owner] = 1'b1;
            ram_wen      = req_wen[owner];
            ram_ren      = req_ren[owner] & ~req_wen[owner];
            ram_addr     = addr_arr[owner];
            ram_store    = store_arr[owner];
            if (is_access) req_load = ram_load;
            if (complete)  req_wait[owner] = 1'b0;
            if (abort_x)   req_err[owner]  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            tcount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner  <= pick_idx;
                        tcount <= '0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    // A withdrawn request ends the transfer silently and keeps its place in the rotation.
                    if (!owner_active) begin
                        state <= IDLE;
                    end else if (is_access) begin
                        rr_ptr <= next_ptr;
                        tcount <= '0;
                        state  <= req_lock[owner] ? XFER : IDLE;
                    end else if (abort_x) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
